// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and shared-ALU signals of alu_arbiter
// slave is the arbiter side; master is the requesters/consumer/ALU side.
interface alu_arbiter_if #(
  parameter int DW = 32
);
  logic          req0_valid;
  logic          req0_ready;
  logic [3:0]    req0_op;
  logic [DW-1:0] req0_rs1;
  logic [DW-1:0] req0_rs2;
  logic [19:0]   req0_imm;

  logic          req1_valid;
  logic          req1_ready;
  logic [3:0]    req1_op;
  logic [DW-1:0] req1_rs1;
  logic [DW-1:0] req1_rs2;
  logic [19:0]   req1_imm;

  logic          resp_valid;
  logic          resp_ready;
  logic          resp_id;
  logic [DW-1:0] resp_rd;
  logic          resp_ovf;
  logic          resp_illegal;

  logic [3:0]    dp_op;
  logic [DW-1:0] dp_rs1;
  logic [DW-1:0] dp_rs2;
  logic [19:0]   dp_bitimm;
  logic [DW-1:0] dp_rd;
  logic          dp_overflow;

  modport slave (
    input  req0_valid, req0_op, req0_rs1, req0_rs2, req0_imm,
    output req0_ready,
    input  req1_valid, req1_op, req1_rs1, req1_rs2, req1_imm,
    output req1_ready,
    output resp_valid, resp_id, resp_rd, resp_ovf, resp_illegal,
    input  resp_ready,
    output dp_op, dp_rs1, dp_rs2, dp_bitimm,
    input  dp_rd, dp_overflow
  );

  modport master (
    output req0_valid, req0_op, req0_rs1, req0_rs2, req0_imm,
    input  req0_ready,
    output req1_valid, req1_op, req1_rs1, req1_rs2, req1_imm,
    input  req1_ready,
    input  resp_valid, resp_id, resp_rd, resp_ovf, resp_illegal,
    output resp_ready,
    input  dp_op, dp_rs1, dp_rs2, dp_bitimm,
    output dp_rd, dp_overflow
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for one shared registered ALU
// One operation in flight: IDLE accepts, EXEC drives the ALU, CAPT samples it, RESP holds the result.
module alu_arbiter #(
  parameter int DW = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_arbiter_if.slave bus,
  output logic         busy_o
);
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_IDLE = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_e;

  state_e        state_q;
  logic [3:0]    op_q;
  logic [DW-1:0] rs1_q;
  logic [DW-1:0] rs2_q;
  logic [19:0]   imm_q;
  logic          id_q;
  logic          last_grant_q;
  logic          resp_valid_q;
  logic          resp_id_q;
  logic [DW-1:0] resp_rd_q;
  logic          resp_ovf_q;
  logic          resp_illegal_q;

  logic          grant_d;
  logic          accept_d;
  logic [3:0]    op_d;
  logic [DW-1:0] rs1_d;
  logic [DW-1:0] rs2_d;
  logic [19:0]   imm_d;
  logic          illegal_d;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_d   = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    accept_d  = (state_q == IDLE) && !rst_i && (bus.req0_valid || bus.req1_valid);
    op_d      = grant_d ? bus.req1_op  : bus.req0_op;
    rs1_d     = grant_d ? bus.req1_rs1 : bus.req0_rs1;
    rs2_d     = grant_d ? bus.req1_rs2 : bus.req0_rs2;
    imm_d     = grant_d ? bus.req1_imm : bus.req0_imm;
    illegal_d = (op_q[3:2] == 2'b11);
  end

  assign bus.req0_ready = accept_d && !grant_d;
  assign bus.req1_ready = accept_d &&  grant_d;

  assign bus.dp_op     = (state_q == EXEC) ? op_q  : OP_IDLE;
  assign bus.dp_rs1    = (state_q == EXEC) ? rs1_q : '0;
  assign bus.dp_rs2    = (state_q == EXEC) ? rs2_q : '0;
  assign bus.dp_bitimm = (state_q == EXEC) ? imm_q : '0;

  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_rd      = resp_rd_q;
  assign bus.resp_ovf     = resp_ovf_q;
  assign bus.resp_illegal = resp_illegal_q;

  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      op_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      imm_q          <= '0;
      id_q           <= 1'b0;
      last_grant_q   <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= 1'b0;
      resp_rd_q      <= '0;
      resp_ovf_q     <= 1'b0;
      resp_illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            op_q         <= op_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            imm_q        <= imm_d;
            id_q         <= grant_d;
            last_grant_q <= grant_d;
            state_q      <= EXEC;
          end
        end
        EXEC: state_q <= CAPT;
        CAPT: begin
          // dp_overflow is only meaningful for add/sub; otherwise it may be stale.
          resp_rd_q      <= illegal_d ? '0 : bus.dp_rd;
          resp_ovf_q     <= !illegal_d && ((op_q == OP_ADD) || (op_q == OP_SUB)) && bus.dp_overflow;
          resp_illegal_q <= illegal_d;
          resp_id_q      <= id_q;
          resp_valid_q   <= 1'b1;
          state_q        <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DW, 32, operand/result width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req0_valid / req1_valid  in  1 each  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  out  1 each  operation from requester N accepted this cycle.
REQ-006 reqN_op  in  4  ALU opcode: 0000 sll, 0001 srl, 0010 sra, 0011 add, 0100 sub, 0101 lui, 0110 slt, 0111 sltu, 1000 xor, 1001 or, 1010 and, 1011 mul.
REQ-007 reqN_rs1, reqN_rs2  in  32 each  operands; reqN_imm  in  20  upper-immediate.
REQ-008 resp_valid  out  1  result available; resp_ready  in  1  consumer takes result.
REQ-009 resp_id  out  1  requester index owning the result; resp_rd  out  32  result.
REQ-010 resp_ovf  out  1  carry/borrow bit; resp_illegal  out  1  opcode was 1100-1111.
REQ-011 dp_op  out  4; dp_rs1, dp_rs2  out  32; dp_bitimm  out  20  drive the shared ALU.
REQ-012 dp_rd  in  32; dp_overflow  in  1  ALU registered outputs, valid one edge after inputs.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 FSM states IDLE, EXEC, CAPT, RESP; one operation in flight at a time.
REQ-015 IDLE: if any reqN_valid, assert reqN_ready (combinational) for the granted requester only; at the edge, latch op/rs1/rs2/imm/id and go to EXEC.
REQ-016 Grant: single requester valid -> that one; both valid -> requester not granted last (round-robin bit last_grant updated on each accept).
REQ-017 reqN_ready SHALL be 0 in EXEC, CAPT, RESP; never both high.
REQ-018 EXEC: dp_op/dp_rs1/dp_rs2/dp_bitimm = latched values for exactly one cycle; next state CAPT.
REQ-019 Outside EXEC, dp_op = 4'b1111 (ALU idle encoding), dp_rs1/dp_rs2/dp_bitimm = 0.
REQ-020 CAPT: capture dp_rd into resp_rd; resp_ovf = dp_overflow if latched op is 0011 or 0100, else 0; next state RESP.
REQ-021 Illegal opcode (1100-1111): still sequenced, resp_rd = 0, resp_ovf = 0, resp_illegal = 1.
REQ-022 RESP: resp_valid = 1, outputs stable until resp_valid && resp_ready edge; then IDLE.
REQ-023 Latency: accept edge at N -> resp_valid high in cycle after edge N+2; min accept-to-accept interval 4 cycles with resp_ready held high.
REQ-024 Back-to-back: new request sampled only in IDLE; a request held valid during RESP is accepted in the cycle following the handshake edge.
REQ-025 resp_ready high while resp_valid low has no effect.
REQ-026 Requester changing reqN_op/operands after accept SHALL NOT affect the in-flight result.

Reset
REQ-027 With rst high at an edge: state IDLE, last_grant = 1 (req0 wins first tie), resp_valid 0, resp_id 0, resp_rd 0, resp_ovf 0, resp_illegal 0, latched operands 0.
REQ-028 rst mid-operation (EXEC/CAPT/RESP): in-flight operation discarded, no response produced; reqN_ready 0 while rst high.
REQ-029 Post-reset dp outputs idle encoding per REQ-019 in first cycle.

Verification
REQ-030 req0 add rs1=0xFFFFFFFF rs2=1 -> resp_id 0, resp_rd 0x00000000, resp_ovf 1, resp_valid 3 cycles after accept edge.
REQ-031 req0 and req1 valid together after reset, resp_ready=1 -> req0 served first, then req1; alternate for 4 ops each, no starvation.
REQ-032 req1 lui imm=0x12345 -> resp_rd 0x12345000, resp_ovf 0 even if dp_overflow stale 1 from prior add.
REQ-033 req0 op 1101 -> resp_illegal 1, resp_rd 0; resp_ready held low 5 cycles -> resp_valid and resp_rd stable, req1_ready stays 0.
REQ-034 rst pulsed during EXEC of req1 sub -> no resp_valid afterward, busy 0, next req0 request accepted in first IDLE cycle.
REQ-035 req0 sltu rs1=1 rs2=0xFFFFFFFF then slt same operands -> resp_rd 1 then 0.
